// File: rtl/axi_ad9234_pack_pkg.sv
// axi_ad9234_pack_pkg
// Shared constants for the AD9234 DMA packer: per-channel and packed word
// widths, the channel-enable mode encodings, and a channel select helper.
package axi_ad9234_pack_pkg;

  localparam int AD9234_CH_WIDTH   = 64;
  localparam int AD9234_WORD_WIDTH = 128;

  // Mode is the concatenation {adc_enable_1, adc_enable_0}.
  typedef logic [1:0] pack_mode_t;

  localparam pack_mode_t MODE_NONE = 2'b00;
  localparam pack_mode_t MODE_CH0  = 2'b01;
  localparam pack_mode_t MODE_CH1  = 2'b10;
  localparam pack_mode_t MODE_BOTH = 2'b11;

  // Data of the single enabled channel in a one-channel mode.
  function automatic logic [AD9234_CH_WIDTH-1:0] select_channel(
    input pack_mode_t                 mode,
    input logic [AD9234_CH_WIDTH-1:0] d0,
    input logic [AD9234_CH_WIDTH-1:0] d1
  );
    return (mode == MODE_CH1) ? d1 : d0;
  endfunction

endpackage

// File: rtl/axi_ad9234_pack_if.sv
// axi_ad9234_pack_if
// Bundles the core-side sample streams and the DMA-side valid/ready bus.
//   adc_enable_0/1, adc_valid_0/1, adc_data_0/1 : per-channel streams (core -> packer)
//   adc_dovf                                    : dropped-word pulse (packer -> core)
//   dma_valid, dma_data, fifo_level             : FWFT FIFO head and occupancy (packer -> DMA)
//   dma_ready                                   : DMA accepts head word (DMA -> packer)
// Modport slave is the packer's view; master is the surrounding system's view.
interface axi_ad9234_pack_if
  import axi_ad9234_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                         adc_enable_0;
  logic                         adc_valid_0;
  logic [AD9234_CH_WIDTH-1:0]   adc_data_0;
  logic                         adc_enable_1;
  logic                         adc_valid_1;
  logic [AD9234_CH_WIDTH-1:0]   adc_data_1;
  logic                         adc_dovf;
  logic                         dma_valid;
  logic [AD9234_WORD_WIDTH-1:0] dma_data;
  logic                         dma_ready;
  logic [LW-1:0]                fifo_level;

  modport slave (
    input  adc_enable_0, adc_valid_0, adc_data_0,
    input  adc_enable_1, adc_valid_1, adc_data_1,
    input  dma_ready,
    output adc_dovf, dma_valid, dma_data, fifo_level
  );

  modport master (
    output adc_enable_0, adc_valid_0, adc_data_0,
    output adc_enable_1, adc_valid_1, adc_data_1,
    output dma_ready,
    input  adc_dovf, dma_valid, dma_data, fifo_level
  );

endinterface

// File: rtl/axi_ad9234_pack_fifo.sv
// axi_ad9234_pack_fifo
// Synchronous first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and word; accepted when not full, or when
//                   full and popped in the same cycle
//   pop_i         : remove head word (ignored when empty)
//   data_o        : head word, forced to zero while empty
//   full_o/empty_o/level_o : status derived from the registered pointers
module axi_ad9234_pack_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  push_ok;
  logic                  pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop in the same cycle frees the slot the write lands in.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

  // Memory is only ever visible behind a non-empty flag, so it is not reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/axi_ad9234_pack.sv
// axi_ad9234_pack
// Packs the enabled AD9234 channel streams into 128-bit DMA words and
// buffers them in a FWFT FIFO.
//   adc_clk  : single clock
//   adc_rstn : asynchronous active-low reset
//   bus      : slave view of axi_ad9234_pack_if (channel streams in,
//              adc_dovf out, DMA valid/ready/data and fifo_level)
// Both channels enabled: one word per beat {ch1, ch0}. One channel enabled:
// two consecutive beats form {second, first}. Words the full FIFO cannot
// take are dropped and reported one cycle later on adc_dovf.
module axi_ad9234_pack
  import axi_ad9234_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              adc_clk,
  input  logic              adc_rstn,
  axi_ad9234_pack_if.slave  bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  pack_mode_t                   mode;
  pack_mode_t                   mode_q;
  logic                         beat;
  logic                         half_eff;
  logic [AD9234_CH_WIDTH-1:0]   cur;

  logic                         half_q, half_d;
  logic [AD9234_CH_WIDTH-1:0]   hold_q, hold_d;
  logic                         pack_valid_q, pack_valid_d;
  logic [AD9234_WORD_WIDTH-1:0] pack_data_q, pack_data_d;
  logic                         adc_dovf_q, adc_dovf_d;

  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic [AD9234_WORD_WIDTH-1:0] fifo_head;
  logic [LW-1:0]                fifo_level;

  assign mode = {bus.adc_enable_1, bus.adc_enable_0};
  assign beat = (bus.adc_enable_0 & bus.adc_valid_0) |
                (bus.adc_enable_1 & bus.adc_valid_1);
  assign cur  = select_channel(mode, bus.adc_data_0, bus.adc_data_1);

  // A mode change discards any half-built word; the beat arriving in the
  // changing cycle starts a fresh word under the new mode.
  assign half_eff = (mode != mode_q) ? 1'b0 : half_q;

  always_comb begin
    half_d       = half_eff;
    hold_d       = hold_q;
    pack_valid_d = 1'b0;
    pack_data_d  = pack_data_q;
    case (mode)
      MODE_BOTH: begin
        half_d = 1'b0;
        if (beat) begin
          pack_valid_d = 1'b1;
          pack_data_d  = {bus.adc_data_1, bus.adc_data_0};
        end
      end
      MODE_CH0, MODE_CH1: begin
        if (beat) begin
          if (!half_eff) begin
            hold_d = cur;
            half_d = 1'b1;
          end else begin
            pack_valid_d = 1'b1;
            pack_data_d  = {cur, hold_q};
            half_d       = 1'b0;
          end
        end
      end
      default: begin
        half_d = 1'b0;
      end
    endcase
  end

  // ---- Pack stage: control state ----
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      mode_q       <= MODE_NONE;
      half_q       <= 1'b0;
      pack_valid_q <= 1'b0;
      adc_dovf_q   <= 1'b0;
    end else begin
      mode_q       <= mode;
      half_q       <= half_d;
      pack_valid_q <= pack_valid_d;
      adc_dovf_q   <= adc_dovf_d;
    end
  end

  // ---- Pack stage: data (qualified by half_q / pack_valid_q) ----
  always_ff @(posedge adc_clk) begin
    hold_q      <= hold_d;
    pack_data_q <= pack_data_d;
  end

  // ---- FIFO stage ----
  assign fifo_pop   = ~fifo_empty & bus.dma_ready;
  assign adc_dovf_d = pack_valid_q & fifo_full & ~fifo_pop;

  axi_ad9234_pack_fifo #(
    .DATA_WIDTH (AD9234_WORD_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (adc_clk),
    .rst_ni  (adc_rstn),
    .push_i  (pack_valid_q),
    .data_i  (pack_data_q),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.adc_dovf   = adc_dovf_q;
  assign bus.dma_valid  = ~fifo_empty;
  assign bus.dma_data   = fifo_head;
  assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_axi_ad9234_pack.sv
// tb_axi_ad9234_pack
// Self-checking bench: a queue-based reference model of the packer and FIFO
// is compared against the DUT every cycle, with directed scenarios carrying
// hand-computed literal expectations, followed by randomized traffic.
module tb_axi_ad9234_pack;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic adc_clk = 1'b0;
  logic adc_rstn = 1'b0;

  always #5 adc_clk = ~adc_clk;

  axi_ad9234_pack_if #(.FIFO_DEPTH(DEPTH)) bus ();

  axi_ad9234_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .adc_clk  (adc_clk),
    .adc_rstn (adc_rstn),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ovf_seen = 0;

  // ---------------- reference model ----------------
  logic [63:0]  pend[$];
  logic [127:0] mq[$];
  logic         stg_v    = 1'b0;
  logic [127:0] stg      = '0;
  logic         exp_dovf = 1'b0;
  logic [1:0]   prev     = 2'b00;

  always @(posedge adc_clk or negedge adc_rstn) begin
    logic [1:0] m;
    logic       b;
    if (!adc_rstn) begin
      pend.delete();
      mq.delete();
      stg_v    = 1'b0;
      exp_dovf = 1'b0;
      prev     = 2'b00;
    end else begin
      // FIFO side, using the word staged on the previous edge
      exp_dovf = 1'b0;
      if (mq.size() > 0 && bus.dma_ready) void'(mq.pop_front());
      if (stg_v) begin
        if (mq.size() < DEPTH) mq.push_back(stg);
        else exp_dovf = 1'b1;
      end
      // input side
      m = {bus.adc_enable_1, bus.adc_enable_0};
      if (m != prev) pend.delete();
      prev  = m;
      stg_v = 1'b0;
      b = (bus.adc_enable_0 & bus.adc_valid_0) | (bus.adc_enable_1 & bus.adc_valid_1);
      if (b) begin
        if (m == 2'b11) begin
          stg   = {bus.adc_data_1, bus.adc_data_0};
          stg_v = 1'b1;
        end else if (m == 2'b01) pend.push_back(bus.adc_data_0);
        else if (m == 2'b10) pend.push_back(bus.adc_data_1);
      end
      if (pend.size() == 2) begin
        stg   = {pend[1], pend[0]};
        stg_v = 1'b1;
        pend.delete();
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    logic [127:0] exp_data;
    @(posedge adc_clk);
    #1;
    exp_data = (mq.size() > 0) ? mq[0] : 128'd0;
    chk("model_dma_valid", 128'(bus.dma_valid), 128'(mq.size() != 0));
    chk("model_dma_data", bus.dma_data, exp_data);
    chk("model_fifo_level", 128'(bus.fifo_level), 128'(mq.size()));
    chk("model_adc_dovf", 128'(bus.adc_dovf), 128'(exp_dovf));
    if (bus.adc_dovf) ovf_seen++;
  endtask

  task automatic set_in(input logic e1, input logic e0, input logic v1, input logic v0,
                        input logic [63:0] d1, input logic [63:0] d0);
    bus.adc_enable_1 = e1;
    bus.adc_enable_0 = e0;
    bus.adc_valid_1  = v1;
    bus.adc_valid_0  = v0;
    bus.adc_data_1   = d1;
    bus.adc_data_0   = d0;
  endtask

  task automatic valids_off();
    bus.adc_valid_1 = 1'b0;
    bus.adc_valid_0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int thr;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    bus.dma_ready = 1'b0;
    cyc();
    cyc();
    chk("reset_dma_valid", 128'(bus.dma_valid), 128'd0);
    chk("reset_fifo_level", 128'(bus.fifo_level), 128'd0);
    chk("reset_dma_data", bus.dma_data, 128'd0);
    chk("reset_adc_dovf", 128'(bus.adc_dovf), 128'd0);
    adc_rstn = 1'b1;
    cyc();

    // Mode 11, four beats, DMA always ready
    bus.dma_ready = 1'b1;
    ovf_seen = 0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 64'h2, 64'h1);
    cyc();
    chk("both_latency_1", 128'(bus.dma_valid), 128'd0);
    cyc();
    chk("both_latency_2", 128'(bus.dma_valid), 128'd1);
    chk("both_word", bus.dma_data, {64'h2, 64'h1});
    cyc();
    cyc();
    valids_off();
    repeat (4) cyc();
    chk("both_drained", 128'(bus.fifo_level), 128'd0);
    chk("both_no_ovf", 128'(ovf_seen), 128'd0);

    // Mode 01, beats A B C D
    bus.dma_ready = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'hA);
    cyc();
    bus.adc_data_0 = 64'hB;
    cyc();
    chk("ch0_latency_1", 128'(bus.dma_valid), 128'd0);
    bus.adc_data_0 = 64'hC;
    cyc();
    chk("ch0_latency_2", 128'(bus.dma_valid), 128'd1);
    chk("ch0_word_ba", bus.dma_data, {64'hB, 64'hA});
    bus.adc_data_0 = 64'hD;
    cyc();
    valids_off();
    cyc();
    chk("ch0_level2", 128'(bus.fifo_level), 128'd2);
    bus.dma_ready = 1'b1;
    cyc();
    chk("ch0_word_dc", bus.dma_data, {64'hD, 64'hC});
    cyc();
    chk("ch0_empty", 128'(bus.fifo_level), 128'd0);

    // Mode 01 beat A, switch to mode 10, beats X Y
    bus.dma_ready = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'hA);
    cyc();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 64'h58, 64'd0);
    cyc();
    bus.adc_data_1 = 64'h59;
    cyc();
    valids_off();
    cyc();
    chk("switch_level1", 128'(bus.fifo_level), 128'd1);
    chk("switch_word_yx", bus.dma_data, {64'h59, 64'h58});
    bus.dma_ready = 1'b1;
    cyc();
    cyc();

    // Overflow: DMA stalled, ten mode-11 beats
    bus.dma_ready = 1'b0;
    ovf_seen = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 64'(100 + i), 64'(i));
      cyc();
    end
    valids_off();
    cyc();
    cyc();
    chk("ovf_level_sat", 128'(bus.fifo_level), 128'd8);
    chk("ovf_pulses", 128'(ovf_seen), 128'd2);
    bus.dma_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_order", bus.dma_data, {64'(100 + i), 64'(i)});
      cyc();
    end
    chk("ovf_drained", 128'(bus.fifo_level), 128'd0);

    // Full FIFO with simultaneous pop and push
    bus.dma_ready = 1'b0;
    ovf_seen = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 64'(200 + i), 64'(50 + i));
      cyc();
    end
    valids_off();
    bus.dma_ready = 1'b1;
    cyc();
    chk("full_pushpop_level", 128'(bus.fifo_level), 128'd8);
    chk("full_pushpop_dovf", 128'(bus.adc_dovf), 128'd0);
    chk("full_pushpop_head", bus.dma_data, {64'd201, 64'd51});
    repeat (10) cyc();
    chk("full_pushpop_no_ovf", 128'(ovf_seen), 128'd0);

    // Reset mid-packet with three words buffered
    bus.dma_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 64'(300 + i), 64'(i));
      cyc();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'hA5);
    cyc();
    valids_off();
    cyc();
    chk("rst_pre_level", 128'(bus.fifo_level), 128'd3);
    adc_rstn = 1'b0;
    #1;
    chk("rst_dma_valid", 128'(bus.dma_valid), 128'd0);
    chk("rst_fifo_level", 128'(bus.fifo_level), 128'd0);
    chk("rst_dma_data", bus.dma_data, 128'd0);
    cyc();
    cyc();
    adc_rstn = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'hB1);
    cyc();
    bus.adc_data_0 = 64'hC1;
    cyc();
    valids_off();
    cyc();
    chk("rst_fresh_level", 128'(bus.fifo_level), 128'd1);
    chk("rst_fresh_word", bus.dma_data, {64'hC1, 64'hB1});

    // Randomized traffic
    thr = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 300 == 0) thr = (thr == 90) ? 30 : 90;
      if ($urandom_range(0, 19) == 0) begin
        bus.adc_enable_0 = 1'($urandom);
        bus.adc_enable_1 = 1'($urandom);
      end
      bus.adc_valid_0 = ($urandom_range(0, 3) != 0);
      bus.adc_valid_1 = ($urandom_range(0, 3) != 0);
      bus.adc_data_0  = {32'($urandom), 32'($urandom)};
      bus.adc_data_1  = {32'($urandom), 32'($urandom)};
      bus.dma_ready   = ($urandom_range(0, 99) < thr);
      cyc();
    end
    valids_off();
    bus.dma_ready = 1'b1;
    repeat (DEPTH + 4) cyc();
    chk("final_empty", 128'(bus.fifo_level), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
